// File: rtl/deser_pkg.sv
// Shared definitions for the serial deserializer: FSM state encodings and the default word width.
`timescale 1ns / 1ps
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } deser_state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_counter.sv
// Enable-gated up-counter with synchronous clear; flags terminal count at WIDTH-1 and saturates there.
`timescale 1ns / 1ps
module bit_counter #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  logic [CW-1:0] r_count;
  logic          w_tc;

  assign w_tc = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_tc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = w_tc;

endmodule

// File: rtl/serial_deserializer.sv
// Start-bit framed serial-to-parallel converter, LSB first, one-cycle valid per completed word.
// Optional even-parity bit and parity_err output when SERIAL_DESER_PARITY_EN is defined.
`timescale 1ns / 1ps
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy
`ifdef SERIAL_DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  deser_state_e     r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_busy;
  logic [CW-1:0]    w_count;
  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_en;
`ifdef SERIAL_DESER_PARITY_EN
  logic             r_par_bit;
  logic             r_par_err;
`endif

  assign w_cnt_clr = (r_state == IDLE);
  assign w_cnt_en  = (r_state == SHIFT) && en;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      r_par_bit <= 1'b0;
      r_par_err <= 1'b0;
`endif
    end else begin
      r_valid   <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      r_par_err <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (en && d) begin
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (en) begin
            r_shift[w_count] <= d;
            if (w_tc) begin
`ifdef SERIAL_DESER_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= DONE;
              r_busy  <= 1'b0;
`endif
            end
          end
        end
`ifdef SERIAL_DESER_PARITY_EN
        PARITY: begin
          if (en) begin
            r_par_bit <= d;
            r_state   <= DONE;
            r_busy    <= 1'b0;
          end
        end
`endif
        // The DONE edge ignores en/d, so a start bit here is dropped.
        DONE: begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
          r_state <= IDLE;
`ifdef SERIAL_DESER_PARITY_EN
          r_par_err <= (^r_shift) ^ r_par_bit;
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;
  assign busy     = r_busy;
`ifdef SERIAL_DESER_PARITY_EN
  assign parity_err = r_par_err;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer (default build): directed frames plus randomized traffic vs a frame-level model.
`timescale 1ns / 1ps
module tb_serial_deserializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         d   = 1'b0;
  logic [W-1:0] data_out;
  logic         valid;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int valid_cnt = 0;
  int busy_cnt = 0;
  int last_valid_edge = 0;
  logic [W-1:0] words[$];

  // Reference: number of bits collected so far (-1 when no frame open) and a pending-word flag.
  int           m_got   = -1;
  logic         m_done  = 1'b0;
  logic [W-1:0] m_acc   = '0;
  logic [W-1:0] m_data  = '0;
  logic         m_valid = 1'b0;

  always #3.5 clk = ~clk;

  serial_deserializer #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .d        (d),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic b);
    if (r) begin
      m_got = -1; m_done = 1'b0; m_acc = '0; m_data = '0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_done) begin
        m_data = m_acc; m_valid = 1'b1; m_done = 1'b0; m_got = -1;
      end else if (m_got < 0) begin
        if (e && b) begin
          m_got = 0; m_acc = '0;
        end
      end else if (e) begin
        m_acc[m_got] = b;
        m_got++;
        if (m_got == int'(W)) m_done = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic b);
    rst = r; en = e; d = b;
    @(posedge clk);
    #1;
    model(r, e, b);
    edge_cnt++;
    chk("valid", valid, m_valid);
    chk("busy", busy, (m_got >= 0) && !m_done);
    chk("data_out", data_out, m_data);
    if (valid === 1'b1) begin
      valid_cnt++;
      last_valid_edge = edge_cnt;
      words.push_back(data_out);
    end
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit gapped);
    logic [W:0] bits;
    int idx;
    logic e;
    bits = {w, 1'b1};
    idx = 0;
    while (idx <= int'(W)) begin
      e = gapped ? ((($time / 64'd20) % 64'd2) == 64'd0) : 1'b1;
      tick(1'b0, e, bits[idx]);
      if (e) idx++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [W-1:0] word_at(input int i);
    if (i < words.size()) return words[i];
    return 'x;
  endfunction

  initial begin
    int v0, b0, s0;
    logic [W-1:0] part;

    // Reset then idle with d=0
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    v0 = valid_cnt; b0 = busy_cnt;
    repeat (20) tick(1'b0, 1'b1, 1'b0);
    chk("idle_valids", valid_cnt - v0, 0);
    chk("idle_busy", busy_cnt - b0, 0);
    chk("idle_data", data_out, 0);

    // Basic frame 0xA5
    words.delete(); v0 = valid_cnt; b0 = busy_cnt; s0 = edge_cnt + 1;
    send_frame(8'hA5, 1'b0);
    idle(3);
    chk("basic_valids", valid_cnt - v0, 1);
    chk("basic_data", word_at(0), 8'hA5);
    chk("basic_latency", last_valid_edge - s0, 9);
    chk("basic_busy_cycles", busy_cnt - b0, 8);

    // Gapped enable
    words.delete(); v0 = valid_cnt; b0 = busy_cnt;
    send_frame(8'hA5, 1'b1);
    idle(3);
    chk("gap_valids", valid_cnt - v0, 1);
    chk("gap_data", word_at(0), 8'hA5);
    chk("gap_busy_held", (busy_cnt - b0) > 8, 1);

    // Reset mid-frame, then 0x81
    words.delete(); v0 = valid_cnt;
    part = 8'h3C;
    tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, part[i]);
    tick(1'b1, 1'b1, 1'b1);
    chk("midrst_busy", busy, 0);
    send_frame(8'h81, 1'b0);
    idle(3);
    chk("midrst_valids", valid_cnt - v0, 1);
    chk("midrst_data", word_at(0), 8'h81);

    // Back-to-back: start bit in DONE cycle is ignored
    words.delete(); v0 = valid_cnt;
    send_frame(8'h0F, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b0);
    idle(3);
    chk("b2b_valids", valid_cnt - v0, 2);
    chk("b2b_word0", word_at(0), 8'h0F);
    chk("b2b_word1", word_at(1), 8'hF0);

    // Randomized traffic with occasional resets
    repeat (1500) begin
      tick(($urandom % 150) == 0, ($urandom % 4) != 0, 1'($urandom % 2));
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
